// File: rtl/arm_trace_pkg.sv
// Shared definitions for the ARM execution trace monitor.
// State encoding, default halt sentinel and record field layout helpers.
package arm_trace_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_HALTED  = 2'b10,
        S_TIMEOUT = 2'b11
    } state_e;

    localparam logic [31:0] HALT_INSTR_DEF = 32'hE000_0000;

    // Record layout, MSB to LSB: {Instr, ALUResult, ALUControl}
    function automatic int rec_w(input int dw, input int cw);
        return 2 * dw + cw;
    endfunction

    function automatic int instr_lsb(input int dw, input int cw);
        return dw + cw;
    endfunction

    function automatic int alu_lsb(input int cw);
        return cw;
    endfunction

    localparam int CTL_LSB = 0;

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer with explicit level tracking and overflow policy.
// Ports: clk/rst_n, push/pop/din in; dout (head), level, full, empty, drop out.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 66,
    parameter bit WRAP  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             pop_ok;
    logic             wr_en;
    logic             ovw;

    always_comb begin
        full   = (level_q == LVL_FULL);
        empty  = (level_q == '0);
        pop_ok = pop & ~empty;
        // At full a write is still taken if a slot frees this edge,
        // or unconditionally when overwriting the oldest entry.
        wr_en  = push & (~full | pop_ok | WRAP);
        drop   = push & full & ~pop_ok;
        ovw    = drop & WRAP;

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = (pop_ok | ovw) ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (wr_en & ~pop_ok & ~full) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok & ~wr_en) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/arm_trace_monitor.sv
// Execution monitor: run/halt/timeout FSM, cycle and drop counters, trace buffer.
// Ports: CLK/RST_N/EN, core record in, RDVALID/RDREADY/RDDATA drain, status out.
module arm_trace_monitor
    import arm_trace_pkg::*;
#(
    parameter int              DW          = 32,
    parameter int              CW          = 2,
    parameter int              DEPTH       = 16,
    parameter logic [DW-1:0]   HALT_INSTR  = DW'(HALT_INSTR_DEF),
    parameter int              TIMEOUT_CYC = 1000,
    parameter int              CNTW        = 16,
    parameter bit              WRAP        = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     EN,
    input  logic [DW-1:0]            Instr,
    input  logic [DW-1:0]            ALUResult,
    input  logic [CW-1:0]            ALUControl,
    input  logic                     RDREADY,
    output logic                     RDVALID,
    output logic [2*DW+CW-1:0]       RDDATA,
    output logic [1:0]               STATE,
    output logic                     HALT,
    output logic                     TIMEOUT,
    output logic [CNTW-1:0]          CYCLES,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [CNTW-1:0]          DROPPED
);

    localparam int RW = rec_w(DW, CW);
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [CNTW-1:0] cycles_q, cycles_d;
    logic [CNTW-1:0] dropped_q, dropped_d;
    logic            halt_q, timeout_q;
    logic            push;
    logic            fifo_empty;
    logic            fifo_drop;
    logic            unused_full;
    logic [RW-1:0]   rec;

    assign rec = {Instr, ALUResult, ALUControl};

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        dropped_d = dropped_q;
        push      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (EN) state_d = S_RUN;
            end
            S_RUN: begin
                if (!EN) begin
                    state_d = S_IDLE;
                end else begin
                    cycles_d = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
                    // Sentinel wins over a timeout landing on the same edge.
                    if (Instr == HALT_INSTR) begin
                        state_d = S_HALTED;
                    end else begin
                        push = 1'b1;
                        if (cycles_q == TO_LAST) state_d = S_TIMEOUT;
                    end
                end
            end
            S_HALTED: ;
            S_TIMEOUT: ;
        endcase
        if (fifo_drop && !(&dropped_q)) begin
            dropped_d = dropped_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cycles_q  <= '0;
            dropped_q <= '0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            dropped_q <= dropped_d;
            halt_q    <= (state_d == S_HALTED);
            timeout_q <= (state_d == S_TIMEOUT);
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW),
        .WRAP  (WRAP)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (RDREADY),
        .din   (rec),
        .dout  (RDDATA),
        .level (LEVEL),
        .full  (unused_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign RDVALID = ~fifo_empty;
    assign STATE   = state_q;
    assign HALT    = halt_q;
    assign TIMEOUT = timeout_q;
    assign CYCLES  = cycles_q;
    assign DROPPED = dropped_q;

endmodule

// File: tb/tb_arm_trace_monitor.sv
// Self-checking bench for arm_trace_monitor: three configurations, shared stimulus.
// Table-driven run/halt sequence plus overflow, timeout and reset sequences.
module tb_arm_trace_monitor;
    import arm_trace_pkg::*;

    localparam int RW = 66;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        EN = 1'b0;
    logic [31:0] Instr = '0;
    logic [31:0] ALUResult = '0;
    logic [1:0]  ALUControl = '0;
    logic        rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;

    logic          v0, v1, v2;
    logic [RW-1:0] d0, d1, d2;
    logic [1:0]    st0, st1, st2;
    logic          h0, h1, h2, t0, t1, t2;
    logic [15:0]   cy0, cy1, cy2, dr0, dr1, dr2;
    logic [4:0]    lv0;
    logic [2:0]    lv1, lv2;

    always #5 CLK = ~CLK;

    arm_trace_monitor #(.DEPTH(16), .TIMEOUT_CYC(8), .WRAP(1'b1)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .Instr(Instr),
        .ALUResult(ALUResult), .ALUControl(ALUControl),
        .RDREADY(rdy0), .RDVALID(v0), .RDDATA(d0), .STATE(st0),
        .HALT(h0), .TIMEOUT(t0), .CYCLES(cy0), .LEVEL(lv0), .DROPPED(dr0));

    arm_trace_monitor #(.DEPTH(4), .WRAP(1'b1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .Instr(Instr),
        .ALUResult(ALUResult), .ALUControl(ALUControl),
        .RDREADY(rdy1), .RDVALID(v1), .RDDATA(d1), .STATE(st1),
        .HALT(h1), .TIMEOUT(t1), .CYCLES(cy1), .LEVEL(lv1), .DROPPED(dr1));

    arm_trace_monitor #(.DEPTH(4), .WRAP(1'b0)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .Instr(Instr),
        .ALUResult(ALUResult), .ALUControl(ALUControl),
        .RDREADY(rdy2), .RDVALID(v2), .RDDATA(d2), .STATE(st2),
        .HALT(h2), .TIMEOUT(t2), .CYCLES(cy2), .LEVEL(lv2), .DROPPED(dr2));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic [1:0]  ctl;
        bit          cap;
        logic [1:0]  exp_st;
        int          exp_cy;
        int          exp_lv;
    } vec_t;

    vec_t          tab [6];
    logic [RW-1:0] sb0 [$];
    logic [RW-1:0] q1 [$];
    logic [RW-1:0] q2 [$];
    int            total = 0;
    int            bad = 0;
    int            e_dr1 = 0;
    int            e_dr2 = 0;

    task automatic chk(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        EN = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
        sb0.delete(); q1.delete(); q2.delete();
        e_dr1 = 0; e_dr2 = 0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a,
                         input logic [1:0] c);
        Instr = i; ALUResult = a; ALUControl = c;
    endtask

    function automatic logic [RW-1:0] mk(input logic [31:0] i,
                                         input logic [31:0] a,
                                         input logic [1:0] c);
        return {i, a, c};
    endfunction

    // Push into the two depth-4 models with their overflow policies.
    task automatic model_push(input logic [RW-1:0] r, input bit pop2);
        if (q1.size() == 4) begin
            void'(q1.pop_front());
            e_dr1++;
        end
        q1.push_back(r);
        if (pop2) void'(q2.pop_front());
        if (q2.size() == 4) e_dr2++;
        else q2.push_back(r);
    endtask

    task automatic drain0(input string name);
        int n = 0;
        logic [RW-1:0] e;
        rdy0 = 1'b1;
        while (v0 && n < 40) begin
            if (sb0.size() == 0) begin
                chk({name, "_extra"}, 1, 0);
            end else begin
                e = sb0.pop_front();
                chk(name, d0, e);
            end
            tick();
            n++;
        end
        rdy0 = 1'b0;
        chk({name, "_left"}, RW'(sb0.size()), 0);
        chk({name, "_lv0"}, RW'(lv0), 0);
    endtask

    task automatic drain12();
        int n = 0;
        logic [RW-1:0] e;
        rdy1 = 1'b1; rdy2 = 1'b1;
        while ((v1 || v2) && n < 20) begin
            if (v1) begin
                if (q1.size() == 0) chk("d1_extra", 1, 0);
                else begin e = q1.pop_front(); chk("d1_data", d1, e); end
            end
            if (v2) begin
                if (q2.size() == 0) chk("d2_extra", 1, 0);
                else begin e = q2.pop_front(); chk("d2_data", d2, e); end
            end
            tick();
            n++;
        end
        rdy1 = 1'b0; rdy2 = 1'b0;
        chk("q1_left", RW'(q1.size()), 0);
        chk("q2_left", RW'(q2.size()), 0);
    endtask

    initial begin
        tab[0] = '{32'h1, 32'hA1, 2'd0, 1'b1, S_RUN, 1, 1};
        tab[1] = '{32'h2, 32'hB2, 2'd1, 1'b1, S_RUN, 2, 2};
        tab[2] = '{32'h3, 32'hC3, 2'd2, 1'b1, S_RUN, 3, 3};
        tab[3] = '{32'h4, 32'hD4, 2'd3, 1'b1, S_RUN, 4, 4};
        tab[4] = '{32'h5, 32'hE5, 2'd0, 1'b1, S_RUN, 5, 5};
        tab[5] = '{32'hE000_0000, 32'hF6, 2'd1, 1'b0, S_HALTED, 6, 5};

        // Reset state and IDLE->RUN transition with no capture
        do_reset();
        chk("rst_st", RW'(st0), RW'(S_IDLE));
        chk("rst_v", RW'(v0), 0);
        chk("rst_lv", RW'(lv0), 0);
        chk("rst_cy", RW'(cy0), 0);
        chk("rst_dr", RW'(dr0), 0);
        EN = 1'b1;
        drive(32'h77, 32'h77, 2'd3);
        tick();
        chk("run_st", RW'(st0), RW'(S_RUN));
        chk("run_lv", RW'(lv0), 0);
        chk("run_cy", RW'(cy0), 0);

        // Table-driven run ending in the halt sentinel
        for (int i = 0; i < 6; i++) begin
            drive(tab[i].instr, tab[i].alu, tab[i].ctl);
            if (tab[i].cap) sb0.push_back(mk(tab[i].instr, tab[i].alu, tab[i].ctl));
            tick();
            chk($sformatf("t%0d_st", i), RW'(st0), RW'(tab[i].exp_st));
            chk($sformatf("t%0d_cy", i), RW'(cy0), RW'(tab[i].exp_cy));
            chk($sformatf("t%0d_lv", i), RW'(lv0), RW'(tab[i].exp_lv));
            chk($sformatf("t%0d_v", i), RW'(v0), 1);
            chk($sformatf("t%0d_head", i), d0, sb0[0]);
        end
        chk("halt_h", RW'(h0), 1);
        chk("halt_t", RW'(t0), 0);
        drive(32'h9, 32'h9, 2'd0);
        tick();
        chk("halt_sticky_lv", RW'(lv0), 5);
        chk("halt_sticky_cy", RW'(cy0), 6);
        drain0("drain1");
        chk("halt_after_drain", RW'(st0), RW'(S_HALTED));

        // Depth-4 overflow, wrap vs discard
        do_reset();
        EN = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) begin
            drive(32'(i), 32'(i * 16), 2'(i));
            model_push(mk(32'(i), 32'(i * 16), 2'(i)), 1'b0);
            tick();
        end
        chk("w1_lv", RW'(lv1), 4);
        chk("w1_dr", RW'(dr1), RW'(e_dr1));
        chk("w1_dr2", RW'(dr1), 2);
        chk("w1_head", RW'(d1[65:34]), 3);
        chk("w0_lv", RW'(lv2), 4);
        chk("w0_dr", RW'(dr2), RW'(e_dr2));
        chk("w0_dr2", RW'(dr2), 2);
        chk("w0_head", RW'(d2[65:34]), 1);
        // Pop and push together at full on the discard instance
        rdy2 = 1'b1;
        drive(32'h7, 32'h70, 2'd3);
        model_push(mk(32'h7, 32'h70, 2'd3), 1'b1);
        tick();
        rdy2 = 1'b0;
        chk("w0pp_lv", RW'(lv2), 4);
        chk("w0pp_dr", RW'(dr2), 2);
        chk("w0pp_head", RW'(d2[65:34]), 2);
        chk("w1ov_dr", RW'(dr1), 3);
        chk("w1ov_head", RW'(d1[65:34]), 4);
        EN = 1'b0;
        tick();
        drain12();

        // Timeout after 8 RUN cycles
        do_reset();
        EN = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(32'(100 + i), 32'(i), 2'(i));
            sb0.push_back(mk(32'(100 + i), 32'(i), 2'(i)));
            tick();
            if (i == 6) chk("to_pre_st", RW'(st0), RW'(S_RUN));
        end
        chk("to_st", RW'(st0), RW'(S_TIMEOUT));
        chk("to_t", RW'(t0), 1);
        chk("to_h", RW'(h0), 0);
        chk("to_cy", RW'(cy0), 8);
        chk("to_lv", RW'(lv0), 8);
        for (int i = 0; i < 3; i++) begin
            drive(i == 1 ? 32'hE000_0000 : 32'h55, 32'h0, 2'd0);
            tick();
        end
        chk("to_sticky_st", RW'(st0), RW'(S_TIMEOUT));
        chk("to_sticky_lv", RW'(lv0), 8);
        chk("to_sticky_cy", RW'(cy0), 8);
        drain0("drain_to");

        // Sentinel exactly on the timeout cycle
        do_reset();
        EN = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                drive(32'hE000_0000, 32'h1, 2'd1);
            end else begin
                drive(32'(200 + i), 32'(i), 2'(i));
                sb0.push_back(mk(32'(200 + i), 32'(i), 2'(i)));
            end
            tick();
        end
        chk("hto_st", RW'(st0), RW'(S_HALTED));
        chk("hto_t", RW'(t0), 0);
        chk("hto_cy", RW'(cy0), 8);
        chk("hto_lv", RW'(lv0), 7);
        drain0("drain_hto");

        // Pause then async reset between edges
        do_reset();
        EN = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'(i + 1), 32'h0, 2'd0);
            tick();
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("pause%0d_cy", i), RW'(cy0), 3);
            chk($sformatf("pause%0d_lv", i), RW'(lv0), 3);
            chk($sformatf("pause%0d_st", i), RW'(st0), RW'(S_IDLE));
        end
        EN = 1'b1;
        drive(32'h4, 32'h0, 2'd0);
        tick();
        chk("resume_cy", RW'(cy0), 3);
        tick();
        chk("resume2_cy", RW'(cy0), 4);
        chk("resume2_lv", RW'(lv0), 4);
        rdy0 = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_st", RW'(st0), RW'(S_IDLE));
        chk("arst_cy", RW'(cy0), 0);
        chk("arst_lv", RW'(lv0), 0);
        chk("arst_v", RW'(v0), 0);
        chk("arst_dr1", RW'(dr1), 0);
        chk("arst_lv1", RW'(lv1), 0);
        #1;
        RST_N = 1'b1;
        EN = 1'b0;
        rdy0 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_trace_monitor.md
Name: arm_trace_monitor

Overview:
- Synthesizable on-chip execution monitor for the single-cycle ARM core.
- Samples the per-cycle {Instr, ALUResult, ALUControl} record and captures it into a parametrised circular trace buffer.
- Detects the halt sentinel instruction and enforces a cycle-timeout watchdog.
- Captured records are drained via a valid/ready read port, so completion and trace checking work in silicon and in simulation without testbench-side $display.

Parameters:
- DW, 32, datapath width of Instr and ALUResult.
- CW, 2, width of ALUControl.
- DEPTH, 16, trace entries; power of two, >=2.
- HALT_INSTR, 32'hE0000000, sentinel instruction that ends a run.
- TIMEOUT_CYC, 1000, maximum RUN cycles before TIMEOUT; >=1.
- CNTW, 16, width of the CYCLES and DROPPED counters.
- WRAP, 1; 1 = overwrite oldest entry when full, 0 = discard new entry when full.

Ports:
- CLK, in, 1, rising-edge clock.
- RST_N, in, 1, asynchronous active-low reset.
- EN, in, 1, enable capture; level-sensitive.
- Instr, in, DW, current instruction.
- ALUResult, in, DW, current ALU result.
- ALUControl, in, CW, current ALU control.
- RDREADY, in, 1, consumer ready.
- RDVALID, out, 1, buffer non-empty.
- RDDATA, out, 2*DW+CW, oldest record {Instr, ALUResult, ALUControl}.
- STATE, out, 2, 00 IDLE, 01 RUN, 10 HALTED, 11 TIMEOUT.
- HALT, out, 1, STATE==HALTED.
- TIMEOUT, out, 1, STATE==TIMEOUT.
- CYCLES, out, CNTW, RUN cycles elapsed.
- LEVEL, out, clog2(DEPTH)+1, entries held.
- DROPPED, out, CNTW, records lost to overflow.

Behaviour:
- Reset (RST_N low, asynchronous): STATE=IDLE, buffer empty (rd/wr pointers 0, LEVEL=0, RDVALID=0), CYCLES=0, DROPPED=0. RDDATA is don't-care while RDVALID=0.
- IDLE:
  - EN=1 -> RUN on the next edge; nothing is captured in the transition cycle.
- RUN, per rising edge:
  - EN=0: -> IDLE. No capture, counters hold. Re-enable resumes counting; counters are not cleared.
  - Instr==HALT_INSTR: -> HALTED. Sentinel record is not captured. CYCLES increments.
  - Otherwise: push record, CYCLES increments. If CYCLES was TIMEOUT_CYC-1 before the increment, -> TIMEOUT; this record is still captured.
  - Halt has priority over timeout in the same cycle.
- HALTED and TIMEOUT are sticky until reset. No further capture. Reading continues.
- Read port:
  - RDDATA is a combinational read of the head entry.
  - Pop on RDVALID & RDREADY at the edge.
  - Pop on empty is impossible (RDVALID=0).
- Push/pop interaction:
  - Simultaneous push and pop: LEVEL unchanged; allowed at full and at empty (at empty the pushed entry becomes head next cycle; no bypass).
  - Full, push, no pop, WRAP=1: oldest entry overwritten, read pointer advances, LEVEL stays DEPTH, DROPPED+1. RDDATA may change while RDVALID is held; consumers must tolerate this in WRAP mode.
  - Full, push, no pop, WRAP=0: record discarded, DROPPED+1, buffer unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. LEVEL is tracked explicitly, 0..DEPTH.
- CYCLES and DROPPED saturate at all-ones. No wrap.
- Latency: a record presented in cycle n is visible on RDDATA in cycle n+1 if the buffer was empty.
- Reset asserted mid-run: immediate clear to the reset values above. An in-flight pop is lost.

Decomposition:
- Package arm_trace_pkg holds:
  - state encoding constants (IDLE/RUN/HALTED/TIMEOUT);
  - default HALT_INSTR;
  - record-width function 2*DW+CW and field offset constants for unpacking RDDATA.
- Sub-module trace_fifo holds the circular buffer, with parameters DEPTH, WIDTH and WRAP.
  - Inputs: push, pop, din.
  - Outputs: dout, level, full, empty, drop.
- arm_trace_monitor holds the FSM, the counters and the fifo instance.

Test Plan:
- Reset then EN=1; feed Instr 1..5, then E0000000 -> STATE=HALTED after 6 RUN edges, CYCLES=6, LEVEL=5, HALT=1. Draining with RDREADY=1 returns Instr 1..5 in order.
- DEPTH=4, WRAP=1; feed 6 non-sentinel records with RDREADY=0 -> LEVEL=4, DROPPED=2, head Instr=3.
- DEPTH=4, WRAP=0; same stimulus -> LEVEL=4, DROPPED=2, head Instr=1. A pop plus push at full keeps LEVEL=4 and DROPPED unchanged.
- TIMEOUT_CYC=8, no sentinel -> TIMEOUT=1 after 8 RUN cycles, CYCLES=8, LEVEL=8 (DEPTH=16). Further inputs are ignored.
- Sentinel presented exactly in cycle TIMEOUT_CYC -> STATE=HALTED (not TIMEOUT), sentinel not captured.
- EN toggled 0 for 3 cycles mid-run, then RST_N pulsed low asynchronously between edges -> counters hold during the pause. All outputs are at reset values before the next CLK edge.
